fetch_unit: RTL and testbench

- Instruction-fetch front end. It owns the PC, issues word reads to instruction memory over a valid/ready request channel, and buffers the returned instructions.
- It presents instructions one at a time to the control/decode stage over a valid/ready handshake.
- The decode side returns the taken-branch decision (pcsrc) and target; fetch redirects on it and discards stale instructions.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_if.sv | 28 ++
 rtl/fetch_sync_fifo.sv | 50 +++++
 rtl/fetch_unit.sv | 85 ++++++++
 tb/tb_fetch_unit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int XLEN_PKG = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN_PKG-1:0] instr;
    logic [XLEN_PKG-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Bundle of the fetch unit's memory, decode and redirect signals.
interface fetch_if #(
  parameter int XLEN = 32
);
  // A transfer happens in a cycle where valid && ready; the sender keeps valid
  // and payload stable until then. The memory response and redirect have no ready.
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            pcsrc;
  logic [XLEN-1:0] pc_target;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, pcsrc, pc_target
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, pcsrc, pc_target
  );
endinterface

// File: rtl/fetch_sync_fifo.sv
// Small synchronous FIFO with flush; a pop frees its slot for a same-cycle push.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != FULL_CNT) || do_pop);
  end

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues credit-limited word reads,
// buffers returned instructions and drops responses made stale by a redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_if.master      bus,
  output fetch_state_e dbg_state
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = 8;
  localparam logic [CW:0] CREDIT = (CW+1)'(DEPTH);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [DW-1:0]   drop_cnt, drop_next;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   buf_count;
  logic [XLEN-1:0] req_pc;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            req_valid, req_fire, rsp_drop, rsp_live, head_valid, pop;

  // Live outstanding equals the request-PC FIFO occupancy: both grow on an
  // accepted request, shrink on a live response and clear on redirect.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_fifo (
    .clk(clk), .rst(rst), .flush(bus.pcsrc),
    .push(req_fire), .din(pc), .pop(rsp_live), .dout(req_pc), .count(outstanding)
  );

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_ibuf (
    .clk(clk), .rst(rst), .flush(bus.pcsrc),
    .push(rsp_live), .din(push_entry), .pop(pop), .dout(head), .count(buf_count)
  );

  always_comb begin
    req_valid  = (state != BOOT) && (({1'b0, outstanding} + {1'b0, buf_count}) < CREDIT);
    req_fire   = req_valid && bus.imem_req_ready;
    rsp_drop   = bus.imem_rsp_valid && (drop_cnt != '0);
    rsp_live   = bus.imem_rsp_valid && (drop_cnt == '0) && (outstanding != '0);
    head_valid = (buf_count != '0);
    pop        = head_valid && bus.instr_ready && !bus.pcsrc;
    push_entry = '{instr: bus.imem_rsp_data, pc: req_pc};

    pc_next    = pc;
    drop_next  = drop_cnt - DW'(rsp_drop);
    if (bus.pcsrc) begin
      pc_next   = {bus.pc_target[XLEN-1:2], 2'b00};
      // Everything still live, plus a request accepted right now, becomes stale.
      drop_next = drop_next + DW'(outstanding - CW'(rsp_live)) + DW'(req_fire);
    end else if (req_fire) begin
      pc_next = pc + XLEN'(4);
    end

    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      default: state_next = (drop_next != '0) ? DRAIN : RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      drop_cnt <= drop_next;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.instr_valid    = head_valid;
  assign bus.instr          = head_valid ? head.instr : '0;
  assign bus.instr_pc       = head_valid ? head.pc : '0;
  assign dbg_state          = state;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table after reset, hand-written redirect/reset
// sequences, then random traffic, all against an in-order expected queue.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  fetch_state_e dbg_state;
  always #5 clk = ~clk;

  fetch_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct {
    logic req_ready; logic instr_ready;
    logic rv; logic [31:0] addr; logic iv; logic [31:0] ipc;
  } vec_t;

  logic [63:0] exp_q[$];
  logic [31:0] got_pc_q[$];
  pend_t       pend[$];
  vec_t        vecs[10];
  logic [31:0] exp_pc;
  int          checks = 0, errors = 0;
  int          cyc = 0, inflight = 0, lat_lo = 1, lat_hi = 1;

  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_instr, s_ipc;
  fetch_state_e s_state;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[31:16]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic check_pcs(input string name, input logic [31:0] p0, input logic [31:0] p1);
    checks++;
    if (got_pc_q.size() < 2) begin
      errors++;
      $display("FAIL %s: got %0d instructions required 2", name, got_pc_q.size());
    end else begin
      check({name, "_first"}, got_pc_q[0], p0);
      check({name, "_second"}, got_pc_q[1], p1);
    end
  endtask

  // ---------------- driver: one clock, memory model and monitor ----------------
  task automatic cycle();
    logic [63:0] e;
    @(negedge clk);
    s_rv = bus.imem_req_valid; s_addr = bus.imem_req_addr;
    s_iv = bus.instr_valid;    s_instr = bus.instr; s_ipc = bus.instr_pc;
    s_state = dbg_state;
    if (rst) begin
      exp_q.delete(); got_pc_q.delete(); pend.delete();
      exp_pc = RESET_PC; inflight = 0;
    end else begin
      if (bus.imem_rsp_valid) begin
        assert (inflight > 0) else $error("memory response with no request in flight");
        if (inflight > 0) inflight--;
      end
      if (s_rv) check("req_addr", s_addr, exp_pc);
      if (s_iv && bus.instr_ready && !bus.pcsrc) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_instr: got pc %h required no instruction", s_ipc);
        end else begin
          e = exp_q.pop_front();
          check("instr_data", s_instr, e[63:32]);
          check("instr_pc", s_ipc, e[31:0]);
          got_pc_q.push_back(s_ipc);
        end
      end
      if (s_rv && bus.imem_req_ready) begin
        exp_q.push_back({mem_word(exp_pc), exp_pc});
        pend.push_back('{addr: s_addr, due: cyc + int'($urandom_range(lat_lo, lat_hi))});
        inflight++;
        exp_pc = exp_pc + 32'd4;
      end
      if (bus.pcsrc) begin
        exp_q.delete(); got_pc_q.delete();
        exp_pc = {bus.pc_target[31:2], 2'b00};
      end
    end
    @(posedge clk); #1;
    cyc++;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    bus.pcsrc = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Free-run with 1-cycle memory and an always-ready decoder: credit limits
    // issue to two of every three cycles.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b0, 32'h00};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h10};

    rst = 1'b1;
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.instr_ready = 1'b1; bus.pcsrc = 1'b1; bus.pc_target = 32'h200;
    exp_pc = RESET_PC;

    // Reset values, with a redirect held during reset that must be ignored.
    do_reset();
    check("rst_req_valid", 32'(s_rv), 32'd0);
    check("rst_instr_valid", 32'(s_iv), 32'd0);
    check("rst_instr", s_instr, 32'd0);
    check("rst_instr_pc", s_ipc, 32'd0);
    check("rst_req_addr", s_addr, RESET_PC);
    check("rst_state", 32'(s_state), 32'(BOOT));

    for (int i = 0; i < 10; i++) begin
      bus.imem_req_ready = vecs[i].req_ready;
      bus.instr_ready    = vecs[i].instr_ready;
      cycle();
      check($sformatf("tbl%0d_req_valid", i), 32'(s_rv), 32'(vecs[i].rv));
      check($sformatf("tbl%0d_req_addr", i), s_addr, vecs[i].addr);
      check($sformatf("tbl%0d_instr_valid", i), 32'(s_iv), 32'(vecs[i].iv));
      check($sformatf("tbl%0d_instr_pc", i), s_ipc, vecs[i].ipc);
    end

    // Decoder stalled: credit stops issue at DEPTH outstanding-plus-buffered.
    bus.instr_ready = 1'b0;
    repeat (10) cycle();
    check("stall_req_valid", 32'(s_rv), 32'd0);
    check("stall_accepted", exp_q.size(), DEPTH);
    bus.instr_ready = 1'b1;
    repeat (12) cycle();

    // Memory not ready: address and valid held, pc frozen.
    do_reset();
    repeat (4) cycle();
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_req_valid", 32'(s_rv), 32'd1);
      check("hold_req_addr", s_addr, 32'h8);
    end
    bus.imem_req_ready = 1'b1;
    repeat (6) cycle();

    // Redirect with two requests in flight (3-cycle memory).
    lat_lo = 3; lat_hi = 3;
    do_reset();
    repeat (3) cycle();
    bus.pcsrc = 1'b1; bus.pc_target = 32'h100;
    cycle();
    check("redir_no_credit", 32'(s_rv), 32'd0);
    bus.pcsrc = 1'b0;
    cycle();
    check("redir_drain_state", 32'(s_state), 32'(DRAIN));
    cycle();
    cycle();
    check("redir_run_state", 32'(s_state), 32'(RUN));
    repeat (10) cycle();
    check_pcs("redir_pcs", 32'h100, 32'h104);

    // Redirect to an unaligned target in a cycle with both a request accepted
    // and a live response arriving.
    lat_lo = 1; lat_hi = 1;
    do_reset();
    repeat (2) cycle();
    bus.pcsrc = 1'b1; bus.pc_target = 32'h103;
    cycle();
    check("same_cycle_req_valid", 32'(s_rv), 32'd1);
    bus.pcsrc = 1'b0;
    cycle();
    check("same_cycle_drain", 32'(s_state), 32'(DRAIN));
    check("target_aligned", s_addr, 32'h100);
    cycle();
    check("same_cycle_run", 32'(s_state), 32'(RUN));
    repeat (8) cycle();
    check_pcs("same_cycle_pcs", 32'h100, 32'h104);

    // Reset mid-stream with two in flight; a concurrent redirect must lose.
    lat_lo = 3; lat_hi = 3;
    do_reset();
    repeat (3) cycle();
    rst = 1'b1; bus.pcsrc = 1'b1; bus.pc_target = 32'h300;
    cycle();
    rst = 1'b0; bus.pcsrc = 1'b0;
    lat_lo = 1; lat_hi = 1;
    cycle();
    check("midrst_req_valid", 32'(s_rv), 32'd0);
    check("midrst_instr_valid", 32'(s_iv), 32'd0);
    check("midrst_req_addr", s_addr, RESET_PC);
    check("midrst_state", 32'(s_state), 32'(BOOT));
    repeat (10) cycle();
    check_pcs("midrst_pcs", RESET_PC, RESET_PC + 32'd4);

    // PC wrap at the top of the address space.
    bus.pcsrc = 1'b1; bus.pc_target = 32'hFFFF_FFFC;
    cycle();
    bus.pcsrc = 1'b0;
    repeat (10) cycle();
    check_pcs("wrap_pcs", 32'hFFFF_FFFC, 32'h0000_0000);

    // Random traffic with variable memory latency and occasional redirects.
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 400; i++) begin
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.instr_ready    = ($urandom_range(0, 3) != 0);
      bus.pcsrc          = ($urandom_range(0, 15) == 0);
      bus.pc_target      = $urandom();
      cycle();
    end
    bus.pcsrc = 1'b0; bus.imem_req_ready = 1'b1; bus.instr_ready = 1'b1;
    repeat (20) cycle();
    check("final_backlog_bounded", 32'(exp_q.size() <= DEPTH), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
